dualport_ram_param: RTL and testbench

- Parametrised successor of the fixed 4-bit × 535 dual-port hash-table RAM.
- Generalises data width, depth and port-A read latency.
- Adds a zero-clear sweep after reset, a port-B ready handshake, out-of-range address detection and an optional saturating read-modify-write add for sketch counters.
- Sits between the hash/lookup pipeline (port A, read-only, pipelined) and the update engine (port B, read/write/add, one op at a time).

---
 rtl/dpram_pkg.sv | 34 +++
 rtl/dualport_ram_param_rd_pipe.sv | 57 +++++
 rtl/dualport_ram_param.sv | 234 +++++++++++++++++++++++
 tb/tb_dualport_ram_param.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// dpram_pkg: shared definitions for the dual-port hash-table RAM.
//   - port-B opcode constants
//   - port-B state enumeration (3-bit encoding)
//   - sat_add(): saturating add used by the optional DPRAM_SAT_ADD_EN path
package dpram_pkg;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        B_INIT   = 3'd0,
        B_IDLE   = 3'd1,
        B_RD     = 3'd2,
        B_WR     = 3'd3,
        B_ADD_RD = 3'd4,
        B_ADD_WR = 3'd5,
        B_ACK    = 3'd6
    } b_state_t;

    // Operands are below 2**w, so "sum exceeds the w-bit maximum" is the
    // same condition as a carry out of bit w-1 in a (w+1)-bit sum.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_v;
        sum   = {1'b0, a} + {1'b0, b};
        max_v = (33'd1 << w) - 33'd1;
        return (sum > max_v) ? max_v[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/dualport_ram_param_rd_pipe.sv
// dpram_rd_pipe: port-A read delay line placed after the RAM output register.
//   Adds RD_LAT-1 register stages of data + valid; RD_LAT = 1 is a wire.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_data, in_valid    RAM register output
//   out_data, out_valid  delayed read data / valid (data is 0 when not valid)
module dpram_rd_pipe #(
    parameter int DATA_W = 4,
    parameter int RD_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    generate
        if (RD_LAT == 1) begin : g_bypass
            assign out_data  = in_data;
            assign out_valid = in_valid;
        end else begin : g_pipe
            localparam int N = RD_LAT - 1;

            logic [DATA_W-1:0] data_q [N];
            logic [DATA_W-1:0] data_d [N];
            logic [N-1:0]      valid_q;
            logic [N-1:0]      valid_d;

            always_comb begin
                data_d[0]  = in_data;
                valid_d[0] = in_valid;
                for (int i = 1; i < N; i++) begin
                    data_d[i]  = data_q[i-1];
                    valid_d[i] = valid_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q <= '0;
                    for (int i = 0; i < N; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign out_data  = data_q[N-1];
            assign out_valid = valid_q[N-1];
        end
    endgenerate

endmodule

// File: rtl/dualport_ram_param.sv
// dualport_ram_param: parametrised dual-port hash-table RAM.
//   Port A: pipelined read-only lookup, one read per cycle, RD_LAT latency.
//   Port B: one op at a time (read / write / saturating add) with readyb.
//   After reset the whole array is swept to zero; init_done then stays high.
//   Optional macro DPRAM_SAT_ADD_EN builds the read-modify-write add; without
//   it opb = 10 completes as an error like the reserved opcode.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   init_done                        clear sweep finished
//   ena, addra -> doa, doa_valid     port-A read
//   enb, opb, addrb, dib, readyb     port-B request / handshake
//   dob, dob_valid, dob_err          port-B completion
//
// state    | meaning
// B_INIT   | clear sweep, writing 0 to address cnt
// B_IDLE   | ready for a port-B request
// B_RD     | registering RAM read data
// B_WR     | committing the write
// B_ADD_RD | registering old value for the add
// B_ADD_WR | committing saturated sum
// B_ACK    | presenting result on the following edge
module dualport_ram_param
    import dpram_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 535,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_done,
    input  logic              ena,
    input  logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] doa,
    output logic              doa_valid,
    input  logic              enb,
    input  logic [1:0]        opb,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dib,
    output logic              readyb,
    output logic [DATA_W-1:0] dob,
    output logic              dob_valid,
    output logic              dob_err
);

    logic [DATA_W-1:0] mem [DEPTH];

    b_state_t          state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              readyb_q, readyb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dob_q, dob_d;
    logic              dob_valid_q, dob_valid_d;
    logic              dob_err_q, dob_err_d;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              b_bad;

    logic              a_req_valid_q, a_req_valid_d;
    logic [ADDR_W-1:0] a_req_addr_q, a_req_addr_d;
    logic              a_req_oob_q, a_req_oob_d;
    logic              a_ram_valid_q, a_ram_valid_d;
    logic [DATA_W-1:0] a_ram_data_q, a_ram_data_d;

    always_comb begin
        b_bad = (32'(addrb) >= 32'(DEPTH)) || (opb == OP_RSV);
`ifndef DPRAM_SAT_ADD_EN
        if (opb == OP_ADD) begin
            b_bad = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        addr_d      = addr_q;
        din_d       = din_q;
        res_d       = res_q;
        err_d       = err_q;
        dob_d       = '0;
        dob_valid_d = 1'b0;
        dob_err_d   = 1'b0;
        we          = 1'b0;
        waddr       = addr_q;
        wdata       = din_q;

        case (state_q)
            B_INIT: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = '0;
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    init_done_d = 1'b1;
                    state_d     = B_IDLE;
                end
            end
            B_IDLE: begin
                if (enb && readyb_q) begin
                    addr_d = addrb;
                    din_d  = dib;
                    err_d  = b_bad;
                    res_d  = '0;
                    if (b_bad) begin
                        state_d = B_ACK;
                    end else begin
                        case (opb)
                            OP_RD:   state_d = B_RD;
                            OP_WR:   state_d = B_WR;
`ifdef DPRAM_SAT_ADD_EN
                            OP_ADD:  state_d = B_ADD_RD;
`endif
                            default: state_d = B_ACK;
                        endcase
                    end
                end
            end
            B_RD: begin
                res_d   = mem[addr_q];
                state_d = B_ACK;
            end
            B_WR: begin
                we      = 1'b1;
                res_d   = din_q;
                state_d = B_ACK;
            end
`ifdef DPRAM_SAT_ADD_EN
            B_ADD_RD: begin
                res_d   = mem[addr_q];
                state_d = B_ADD_WR;
            end
            B_ADD_WR: begin
                we      = 1'b1;
                wdata   = DATA_W'(sat_add(32'(res_q), 32'(din_q), DATA_W));
                res_d   = wdata;
                state_d = B_ACK;
            end
`endif
            B_ACK: begin
                dob_d       = err_q ? '0 : res_q;
                dob_valid_d = 1'b1;
                dob_err_d   = err_q;
                state_d     = B_IDLE;
            end
            default: state_d = B_IDLE;
        endcase

        readyb_d = (state_d == B_IDLE);
    end

    // Port A registers the address on the sampling edge and reads the array
    // one cycle later, so a port-B write committed on that same edge is
    // already visible: write-first without a bypass mux.
    always_comb begin
        a_req_valid_d = ena && init_done_q;
        a_req_addr_d  = addra;
        a_req_oob_d   = (32'(addra) >= 32'(DEPTH));
        a_ram_valid_d = a_req_valid_q;
        a_ram_data_d  = (a_req_valid_q && !a_req_oob_q) ? mem[a_req_addr_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= B_INIT;
            cnt_q         <= '0;
            init_done_q   <= 1'b0;
            readyb_q      <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            res_q         <= '0;
            err_q         <= 1'b0;
            dob_q         <= '0;
            dob_valid_q   <= 1'b0;
            dob_err_q     <= 1'b0;
            a_req_valid_q <= 1'b0;
            a_req_addr_q  <= '0;
            a_req_oob_q   <= 1'b0;
            a_ram_valid_q <= 1'b0;
            a_ram_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            init_done_q   <= init_done_d;
            readyb_q      <= readyb_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            res_q         <= res_d;
            err_q         <= err_d;
            dob_q         <= dob_d;
            dob_valid_q   <= dob_valid_d;
            dob_err_q     <= dob_err_d;
            a_req_valid_q <= a_req_valid_d;
            a_req_addr_q  <= a_req_addr_d;
            a_req_oob_q   <= a_req_oob_d;
            a_ram_valid_q <= a_ram_valid_d;
            a_ram_data_q  <= a_ram_data_d;
        end
    end

    // A write landing on a reset edge is dropped; the sweep re-zeroes anyway.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[waddr] <= wdata;
        end
    end

    dpram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_ram_data_q),
        .in_valid  (a_ram_valid_q),
        .out_data  (doa),
        .out_valid (doa_valid)
    );

    assign init_done = init_done_q;
    assign readyb    = readyb_q;
    assign dob       = dob_q;
    assign dob_valid = dob_valid_q;
    assign dob_err   = dob_err_q;

endmodule

// File: tb/tb_dualport_ram_param.sv
// Bench for dualport_ram_param: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of both ports.
module tb_dualport_ram_param;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 535;
    localparam int ADDR_W = 10;
    localparam int RD_LAT = 3;
    localparam int MAXV   = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_done;
    logic              ena;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] doa;
    logic              doa_valid;
    logic              enb;
    logic [1:0]        opb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dib;
    logic              readyb;
    logic [DATA_W-1:0] dob;
    logic              dob_valid;
    logic              dob_err;

    dualport_ram_param #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .ena       (ena),
        .addra     (addra),
        .doa       (doa),
        .doa_valid (doa_valid),
        .enb       (enb),
        .opb       (opb),
        .addrb     (addrb),
        .dib       (dib),
        .readyb    (readyb),
        .dob       (dob),
        .dob_valid (dob_valid),
        .dob_err   (dob_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit err; int val; } bres_t;

    int    mem_m [DEPTH];
    int    exp_a [int];
    bres_t exp_b [int];
    int    cmt_addr [int];
    int    cmt_val [int];
    bit    live       = 0;
    bit    init_m     = 0;
    bit    readyb_m   = 0;
    int    sweep_left = DEPTH;
    int    b_done     = 0;
    int    b_acc_cnt  = 0;

    always @(posedge clk) begin
        bit    ready_prev;
        bit    err;
        int    a;
        int    lat;
        bres_t r;
        cyc++;
        if (!rst_n) begin
            live       = 1;
            init_m     = 0;
            readyb_m   = 0;
            sweep_left = DEPTH;
            b_done     = 0;
            foreach (mem_m[i]) mem_m[i] = 0;
            exp_a.delete();
            exp_b.delete();
            cmt_addr.delete();
            cmt_val.delete();
        end else if (live) begin
            ready_prev = init_m && (cyc - 1 >= b_done);
            if (cmt_addr.exists(cyc)) begin
                mem_m[cmt_addr[cyc]] = cmt_val[cyc];
                cmt_addr.delete(cyc);
                cmt_val.delete(cyc);
            end
            if (init_m && ena)
                exp_a[cyc + RD_LAT] = (int'(addra) < DEPTH) ? mem_m[addra] : 0;
            if (ready_prev && enb) begin
                a   = int'(addrb);
                err = (a >= DEPTH) || (opb == 2'b11);
`ifndef DPRAM_SAT_ADD_EN
                if (opb == 2'b10) err = 1;
`endif
                r.err = err;
                r.val = 0;
                if (err) begin
                    lat = 1;
                end else if (opb == 2'b00) begin
                    lat   = 2;
                    r.val = mem_m[a];
                end else if (opb == 2'b01) begin
                    lat   = 2;
                    r.val = int'(dib);
                    cmt_addr[cyc + 1] = a;
                    cmt_val[cyc + 1]  = r.val;
                end else begin
                    lat   = 3;
                    r.val = mem_m[a] + int'(dib);
                    if (r.val > MAXV) r.val = MAXV;
                    cmt_addr[cyc + 2] = a;
                    cmt_val[cyc + 2]  = r.val;
                end
                exp_b[cyc + lat] = r;
                b_done = cyc + lat;
                b_acc_cnt++;
            end
            if (!init_m) begin
                sweep_left--;
                if (sweep_left == 0) init_m = 1;
            end
            readyb_m = init_m && (cyc >= b_done);
        end
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (live) begin
            chk("init_done", init_done, init_m);
            chk("readyb", readyb, readyb_m);
            if (exp_a.exists(cyc)) begin
                chk("doa_valid", doa_valid, 1);
                chk("doa", doa, exp_a[cyc]);
                exp_a.delete(cyc);
            end else begin
                chk("doa_valid_idle", doa_valid, 0);
                chk("doa_idle", doa, 0);
            end
            if (exp_b.exists(cyc)) begin
                chk("dob_valid", dob_valid, 1);
                chk("dob_err", dob_err, exp_b[cyc].err);
                chk("dob", dob, exp_b[cyc].val);
                exp_b.delete(cyc);
            end else begin
                chk("dob_valid_idle", dob_valid, 0);
                chk("dob_err_idle", dob_err, 0);
                chk("dob_idle", dob, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return ADDR_W'($urandom_range(DEPTH, 1023));
        return ADDR_W'($urandom_range(0, 31));
    endfunction

    task automatic rd_a(input int a);
        ena   = 1'b1;
        addra = ADDR_W'(a);
        tick();
        ena   = 1'b0;
    endtask

    // Issues one port-B op; optionally fires a port-A read sampled on the
    // edge after acceptance, and optionally keeps enb high (with scrambled
    // operands) for `hold` extra cycles while the op is in flight.
    task automatic do_b(input logic [1:0] op, input int a, input int d,
                        input int hold, input int a_addr);
        int start;
        int n;
        start = b_acc_cnt;
        n     = 0;
        opb   = op;
        addrb = ADDR_W'(a);
        dib   = DATA_W'(d);
        enb   = 1'b1;
        do begin
            tick();
            n++;
        end while (b_acc_cnt == start && n < 200);
        chk("b_accept", b_acc_cnt - start, 1);
        if (a_addr >= 0) begin
            ena   = 1'b1;
            addra = ADDR_W'(a_addr);
        end
        opb = 2'($urandom);
        addrb = ADDR_W'($urandom);
        dib = DATA_W'($urandom);
        enb = (hold > 0);
        tick();
        ena = 1'b0;
        for (int i = 1; i < hold; i++) tick();
        enb = 1'b0;
        n = 0;
        while (cyc < b_done && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        rst_n = 1'b1;
        while (!init_done && n < DEPTH + 50) begin
            addra = ADDR_W'($urandom_range(0, 1023));
            tick();
            n++;
        end
        chk(tag, n, DEPTH);
        ena = 1'b0;
        enb = 1'b0;
    endtask

    initial begin
        int acc;
        rst_n = 1'b0;
        ena   = 1'b0;
        enb   = 1'b0;
        opb   = 2'b00;
        addra = '0;
        addrb = '0;
        dib   = '0;
        repeat (3) tick();

        // sweep with both ports requesting: nothing may be accepted
        ena   = 1'b1;
        enb   = 1'b1;
        addrb = ADDR_W'(3);
        wait_init("init_latency");

        for (int a = 0; a < DEPTH; a++) begin
            ena   = 1'b1;
            addra = ADDR_W'(a);
            tick();
        end
        ena = 1'b0;
        repeat (RD_LAT + 1) tick();

        do_b(2'b01, 17, 9, 0, -1);
        rd_a(17);
        do_b(2'b00, 17, 0, 1, -1);

        do_b(2'b01, 5, 12, 0, -1);
        do_b(2'b10, 5, 2, 2, -1);
        do_b(2'b10, 5, 5, 0, -1);
        do_b(2'b00, 5, 0, 0, -1);
        rd_a(5);

        do_b(2'b01, 100, 3, 0, 100);
        for (int a = 0; a < 10; a++) begin
            ena   = 1'b1;
            addra = ADDR_W'(a);
            tick();
        end
        ena = 1'b0;

        do_b(2'b00, 600, 0, 0, -1);
        rd_a(600);
        do_b(2'b11, 3, 4, 0, -1);
        do_b(2'b01, 600, 7, 0, -1);
        repeat (RD_LAT + 1) tick();

        for (int i = 0; i < 2000; i++) begin
            ena   = 1'($urandom);
            addra = rand_addr();
            enb   = 1'($urandom);
            opb   = 2'($urandom);
            addrb = rand_addr();
            dib   = DATA_W'($urandom);
            tick();
        end
        ena = 1'b0;
        enb = 1'b0;
        repeat (RD_LAT + 4) tick();

        // reset while the add is committing
        do_b(2'b01, 5, 7, 0, -1);
        opb   = 2'b10;
        addrb = ADDR_W'(5);
        dib   = DATA_W'(1);
        enb   = 1'b1;
        acc   = b_acc_cnt;
        for (int n = 0; n < 50 && b_acc_cnt == acc; n++) tick();
        chk("b_accept_add", b_acc_cnt - acc, 1);
        enb = 1'b0;
        tick();
        rst_n = 1'b0;
        repeat (3) tick();
        wait_init("init_latency_rerun");
        rd_a(5);
        do_b(2'b00, 5, 0, 0, -1);
        repeat (RD_LAT + 4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
